// File: rtl/ce_pulse_gen.sv
// Count-enable strobe source: debounced pushbutton edge (MODE=0) or prescaler tick (MODE=1).
// CE is registered. Press-to-CE latency is DEBOUNCE_CYCLES+2 edges. There is no backpressure.
module ce_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_DIV        = 50,
   parameter int CNT_W           = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   input  logic       MODE,
   output logic       CE,
   output logic       BTN_STABLE,
   output logic [7:0] PULSE_CNT
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(AUTO_DIV - 1);

   logic             sync0, sync1;
   logic             stable, stable_d;
   logic             mode_q;
   logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
   logic [CNT_W-1:0] presc, presc_nxt;
   logic             stable_nxt;
   logic             auto_run;
   logic             ce_nxt;

   // The first auto edge only arms the prescaler (mode_q), so the first tick
   // lands AUTO_DIV edges after MODE is seen and AUTO_DIV=1 goes high on the second.
   always_comb begin
      db_cnt_nxt = '0;
      stable_nxt = stable;
      presc_nxt  = '0;
      auto_run   = MODE & mode_q;
      ce_nxt     = 1'b0;

      if (sync1 != stable) begin
         if (db_cnt == DB_LAST) begin
            stable_nxt = sync1;
         end else begin
            db_cnt_nxt = db_cnt + 1'b1;
         end
      end

      if (auto_run && (presc != DIV_LAST)) begin
         presc_nxt = presc + 1'b1;
      end

      if (MODE) begin
         ce_nxt = auto_run & (presc == DIV_LAST);
      end else begin
         ce_nxt = stable & ~stable_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         stable    <= 1'b0;
         stable_d  <= 1'b0;
         mode_q    <= 1'b0;
         db_cnt    <= '0;
         presc     <= '0;
         CE        <= 1'b0;
         PULSE_CNT <= 8'd0;
      end else begin
         sync0     <= BTN;
         sync1     <= sync0;
         stable    <= stable_nxt;
         stable_d  <= stable;
         mode_q    <= MODE;
         db_cnt    <= db_cnt_nxt;
         presc     <= presc_nxt;
         CE        <= ce_nxt;
         PULSE_CNT <= PULSE_CNT + {7'd0, CE};
      end
   end

   assign BTN_STABLE = stable;

endmodule
